// File: rtl/cube_job_scheduler.sv
// cube_job_scheduler: job FIFO + launcher in front of systolic_cube_with_mc.
// Each job carries {src, dst} base addresses that relocate the cube's RAM
// read/write addresses while that job runs. Optional macro
// CUBE_SCHED_TIMEOUT_EN adds a RUN watchdog that raises a sticky oError and
// abandons the hung job without counting it.
module cube_job_scheduler #(
  parameter int RAM_DEPTH = 2048,
  parameter int QUEUE_DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int ADDR_W = $clog2(RAM_DEPTH)
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iJobValid,
  output logic              oJobReady,
  input  logic [ADDR_W-1:0] iJobSrcBase,
  input  logic [ADDR_W-1:0] iJobDstBase,
  output logic              oBusy,
  output logic              oJobDone,
  output logic [15:0]       oDoneCount,
  output logic              oCubeStart,
  input  logic              iCubeReady,
  input  logic [ADDR_W-1:0] iCubeAddrRd,
  output logic [ADDR_W-1:0] oAddrForDataWeightRam,
  input  logic              iCubeWrEn,
  input  logic [ADDR_W-1:0] iCubeAddrWr,
  input  logic [31:0]       iCubeData,
  output logic              oWrEnForResultRam,
  output logic [ADDR_W-1:0] oAddrForResultRam,
  output logic [31:0]       oDataToResultRam,
  output logic              oError
);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_COMPLETE} state_t;
  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_fifo_src [QUEUE_DEPTH];
  logic [ADDR_W-1:0] r_fifo_dst [QUEUE_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic [ADDR_W-1:0] r_src_q, r_dst_q;
  logic              r_ready_d;
  logic [15:0]       r_done_count;
  logic              w_full, w_empty, w_push, w_pop, w_ready_edge;
  logic              w_timeout, w_suppress;

  assign w_full       = r_count == (PTR_W+1)'(QUEUE_DEPTH);
  assign w_empty      = r_count == '0;
  assign w_push       = iJobValid && !w_full;
  assign w_pop        = r_state == S_LAUNCH;
  assign w_ready_edge = iCubeReady && !r_ready_d;

  assign oJobReady  = !w_full;
  assign oBusy      = r_state != S_IDLE || !w_empty;
  assign oDoneCount = r_done_count;

  // Relocation is purely combinational; bases are frozen for the whole job.
  assign oAddrForDataWeightRam = iCubeAddrRd + r_src_q;
  assign oAddrForResultRam     = iCubeAddrWr + r_dst_q;
  assign oDataToResultRam      = iCubeData;

  // Job storage; entries need no reset because occupancy is tracked separately.
  always_ff @(posedge iClk) begin
    if (w_push) begin
      r_fifo_src[r_wr_ptr] <= iJobSrcBase;
      r_fifo_dst[r_wr_ptr] <= iJobDstBase;
    end
  end

  // FIFO pointers and occupancy; push and pop in the same cycle cancel out.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= (w_push && !w_pop) ? r_count + 1'b1 :
                 (!w_push && w_pop) ? r_count - 1'b1 : r_count;
    end
  end

  // Active job bases, ready history for edge detection, completion counter.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_src_q      <= '0;
      r_dst_q      <= '0;
      r_ready_d    <= 1'b0;
      r_done_count <= '0;
    end else begin
      r_ready_d <= iCubeReady;
      if (r_state == S_LAUNCH) begin
        r_src_q <= r_fifo_src[r_rd_ptr];
        r_dst_q <= r_fifo_dst[r_rd_ptr];
      end
      if (r_state == S_COMPLETE && !w_suppress) r_done_count <= r_done_count + 16'd1;
    end
  end

`ifdef CUBE_SCHED_TIMEOUT_EN
  logic [31:0] r_wd;
  logic        r_err, r_timed_out;
  assign w_timeout  = r_state == S_RUN && !w_ready_edge && r_wd == 32'(TIMEOUT_CYCLES - 1);
  assign w_suppress = r_timed_out;
  assign oError     = r_err;
  // Watchdog: counts RUN cycles of the current job; a timeout is sticky in r_err.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_wd        <= '0;
      r_err       <= 1'b0;
      r_timed_out <= 1'b0;
    end else begin
      r_wd <= (r_state == S_LAUNCH) ? '0 : (r_state == S_RUN) ? r_wd + 32'd1 : r_wd;
      if (w_timeout) begin
        r_err       <= 1'b1;
        r_timed_out <= 1'b1;
      end else if (r_state == S_LAUNCH) r_timed_out <= 1'b0;
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = TIMEOUT_CYCLES[0];
  assign w_timeout    = 1'b0;
  assign w_suppress   = 1'b0;
  assign oError       = 1'b0;
`endif

  // State register.
  always_ff @(posedge iClk) begin
    if (iRst) r_state <= S_IDLE;
    else r_state <= w_state_nxt;
  end

  // Next state and handshake outputs; a job pushed this cycle counts as queued.
  always_comb begin
    w_state_nxt       = r_state;
    oCubeStart        = 1'b0;
    oJobDone          = 1'b0;
    oWrEnForResultRam = 1'b0;
    case (r_state)
      S_IDLE: w_state_nxt = (!w_empty || w_push) ? S_LAUNCH : S_IDLE;
      S_LAUNCH: begin
        oCubeStart  = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        oWrEnForResultRam = iCubeWrEn;
        w_state_nxt       = (w_ready_edge || w_timeout) ? S_COMPLETE : S_RUN;
      end
      default: begin
        oJobDone    = !w_suppress;
        w_state_nxt = (!w_empty || w_push) ? S_LAUNCH : S_IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_cube_job_scheduler.sv
// tb_cube_job_scheduler: directed + randomized bench with a job-timeline model.
module tb_cube_job_scheduler;
  localparam int AW = 11;
  localparam int DEPTH = 2048;
  localparam int QD = 4;
  localparam int TO = 16;

  logic          clk = 0;
  logic          iRst = 1, iJobValid = 0, iCubeReady = 0, iCubeWrEn = 0;
  logic [AW-1:0] iJobSrcBase = 0, iJobDstBase = 0, iCubeAddrRd = 0, iCubeAddrWr = 0;
  logic [31:0]   iCubeData = 0;
  logic          oJobReady, oBusy, oJobDone, oCubeStart, oWrEnForResultRam, oError;
  logic [15:0]   oDoneCount;
  logic [AW-1:0] oAddrForDataWeightRam, oAddrForResultRam;
  logic [31:0]   oDataToResultRam;

  cube_job_scheduler #(.RAM_DEPTH(DEPTH), .QUEUE_DEPTH(QD), .TIMEOUT_CYCLES(TO)) dut (
    .iClk(clk), .iRst(iRst), .iJobValid(iJobValid), .oJobReady(oJobReady),
    .iJobSrcBase(iJobSrcBase), .iJobDstBase(iJobDstBase), .oBusy(oBusy),
    .oJobDone(oJobDone), .oDoneCount(oDoneCount), .oCubeStart(oCubeStart),
    .iCubeReady(iCubeReady), .iCubeAddrRd(iCubeAddrRd),
    .oAddrForDataWeightRam(oAddrForDataWeightRam), .iCubeWrEn(iCubeWrEn),
    .iCubeAddrWr(iCubeAddrWr), .iCubeData(iCubeData),
    .oWrEnForResultRam(oWrEnForResultRam), .oAddrForResultRam(oAddrForResultRam),
    .oDataToResultRam(oDataToResultRam), .oError(oError));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  bit chk_en = 0, auto_rdy = 0;
  int rc = 0, tgt = 3;

  // Job timeline model: pending jobs as queues; the active job's phase is
  // 0 waiting, 1 start cycle, 2 cube busy, 3 done cycle.
  int qs[$], qd[$];
  int m_ph = 0, m_src = 0, m_dst = 0, m_cnt = 0, m_wd = 0;
  bit m_prv = 0, m_err = 0, m_to = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    bit psh, more, red, to;
    if (iRst) begin
      qs.delete(); qd.delete();
      m_ph = 0; m_src = 0; m_dst = 0; m_cnt = 0; m_wd = 0;
      m_prv = 0; m_err = 0; m_to = 0;
    end else begin
      psh  = iJobValid && qs.size() < QD;
      more = qs.size() > 0 || psh;
      red  = iCubeReady && !m_prv;
      to   = 0;
`ifdef CUBE_SCHED_TIMEOUT_EN
      to = m_ph == 2 && !red && m_wd == TO - 1;
`endif
      m_prv = iCubeReady;
      case (m_ph)
        0: if (more) m_ph = 1;
        1: begin
          m_src = qs.pop_front(); m_dst = qd.pop_front();
          m_wd = 0; m_to = 0; m_ph = 2;
        end
        2: begin
          m_wd++;
          if (to) begin m_err = 1; m_to = 1; end
          if (red || to) m_ph = 3;
        end
        default: begin
          if (!m_to) m_cnt = (m_cnt + 1) % 65536;
          m_ph = more ? 1 : 0;
        end
      endcase
      if (psh) begin qs.push_back(int'(iJobSrcBase)); qd.push_back(int'(iJobDstBase)); end
    end
    chk_en = 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("job_ready", oJobReady, qs.size() < QD);
      chk("busy", oBusy, m_ph != 0 || qs.size() > 0);
      chk("cube_start", oCubeStart, m_ph == 1);
      chk("job_done", oJobDone, m_ph == 3 && !m_to);
      chk("done_count", oDoneCount, m_cnt);
      chk("rd_addr", oAddrForDataWeightRam, (int'(iCubeAddrRd) + m_src) % DEPTH);
      chk("wr_addr", oAddrForResultRam, (int'(iCubeAddrWr) + m_dst) % DEPTH);
      chk("wr_data", oDataToResultRam, iCubeData);
      chk("wr_en", oWrEnForResultRam, iCubeWrEn && m_ph == 2);
      chk("error", oError, m_err);
    end
  end

  // One clock step; the cube stand-in pulses ready 2..6 busy cycles after a start.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (auto_rdy) begin
      if (m_ph == 2) begin
        rc++;
        iCubeReady = (rc == tgt);
      end else begin
        rc = 0;
        iCubeReady = 0;
        tgt = $urandom_range(2, 6);
      end
    end
  endtask

  task automatic push(int s, int d);
    iJobValid = 1; iJobSrcBase = AW'(s); iJobDstBase = AW'(d);
    cyc();
    iJobValid = 0;
  endtask

  task automatic wait_ph(int p, int lim, string name);
    int k = 0;
    while (m_ph != p && k < lim) begin cyc(); k++; end
    if (m_ph != p) chk({name, "_timeout"}, m_ph, p);
  endtask

  initial begin
    cyc(); cyc();
    iRst = 0;
    iCubeAddrRd = 11'h123; iCubeAddrWr = 11'h045;
    #1;
    chk("lit_reset_ready", oJobReady, 1);
    chk("lit_reset_busy", oBusy, 0);
    chk("lit_reset_count", oDoneCount, 0);
    chk("lit_reset_passthru", oAddrForDataWeightRam, 11'h123);
    // single job
    push(11'h100, 11'h200);
    #1 chk("lit_start_after_push", oCubeStart, 1);
    iCubeAddrRd = 11'h005; iCubeAddrWr = 11'h003; iCubeWrEn = 1; iCubeData = 32'hDEADBEEF;
    cyc();
    #1;
    chk("lit_rd_reloc", oAddrForDataWeightRam, 11'h105);
    chk("lit_wr_reloc", oAddrForResultRam, 11'h203);
    chk("lit_wr_en_run", oWrEnForResultRam, 1);
    chk("lit_start_once", oCubeStart, 0);
    iCubeWrEn = 0;
    cyc(); cyc();
    iCubeReady = 1;
    cyc();
    iCubeReady = 0;
    #1 chk("lit_done_pulse", oJobDone, 1);
    cyc();
    #1;
    chk("lit_done_count1", oDoneCount, 1);
    chk("lit_done_once", oJobDone, 0);
    chk("lit_idle_busy", oBusy, 0);
    // wrap
    push(11'h7FF, 11'h7FE);
    cyc();
    iCubeAddrRd = 11'h002; iCubeAddrWr = 11'h005;
    #1;
    chk("lit_rd_wrap", oAddrForDataWeightRam, 11'h001);
    chk("lit_wr_wrap", oAddrForResultRam, 11'h003);
    iCubeReady = 1; cyc(); iCubeReady = 0; cyc();
    iCubeWrEn = 1;
    #1 chk("lit_wr_en_idle", oWrEnForResultRam, 0);
    iCubeWrEn = 0;
    // five jobs: one running, four queued fill the queue
    push(11'h010, 11'h020);
    cyc();
    for (int i = 1; i < 5; i++) push(11'h010 * (i + 1), 11'h020 * (i + 1));
    #1 chk("lit_full_ready", oJobReady, 0);
    auto_rdy = 1;
    for (int k = 0; k < 200 && m_cnt != 7; k++) cyc();
    wait_ph(0, 20, "drain5");
    #1 chk("lit_done_count7", oDoneCount, 7);
    // reset while running with two queued
    auto_rdy = 0; iCubeReady = 0;
    iJobValid = 1; iJobSrcBase = 11'h300; iJobDstBase = 11'h400;
    cyc(); cyc(); cyc();
    iJobValid = 0;
    cyc();
    iRst = 1;
    cyc();
    iRst = 0; iCubeWrEn = 1;
    #1;
    chk("lit_rst_start", oCubeStart, 0);
    chk("lit_rst_busy", oBusy, 0);
    chk("lit_rst_ready", oJobReady, 1);
    chk("lit_rst_count", oDoneCount, 0);
    chk("lit_rst_wren", oWrEnForResultRam, 0);
    iCubeWrEn = 0;
    for (int k = 0; k < 10; k++) cyc();
`ifdef CUBE_SCHED_TIMEOUT_EN
    push(11'h111, 11'h222);
    push(11'h333, 11'h444);
    for (int k = 0; k < TO + 3; k++) cyc();
    #1;
    chk("lit_to_error", oError, 1);
    chk("lit_to_count", oDoneCount, 0);
    chk("lit_to_next_run", m_ph == 2 || m_ph == 1, 1);
    auto_rdy = 1;
    wait_ph(0, 100, "to_drain");
`endif
    // randomized traffic
    auto_rdy = 1;
    for (int k = 0; k < 3000; k++) begin
      iJobValid   = ($urandom_range(0, 3) == 0);
      iJobSrcBase = AW'($urandom);
      iJobDstBase = AW'($urandom);
      iCubeAddrRd = AW'($urandom);
      iCubeAddrWr = AW'($urandom);
      iCubeWrEn   = $urandom_range(0, 1) == 1;
      iCubeData   = $urandom;
      cyc();
    end
    iJobValid = 0;
    for (int k = 0; k < 200 && (m_ph != 0 || qs.size() > 0); k++) cyc();
    #1 chk("lit_final_idle", oBusy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
